// File: rtl/goal_detector.sv
`default_nettype none
// ============================================================================
//  Module   : goal_detector
//  Purpose  : Conditions the raw active-low IR beam-break sensor of the basket
//             game. The sensor input is synchronized, sampled on a slow tick
//             and debounced with hysteresis. Rim rattles are absorbed by a
//             hold-off window, and a stuck or blocked sensor is flagged.
//             The block emits one single-cycle goal pulse per ball, keeps a
//             saturating goal tally and reports busy/fault status.
//  Revision : 1.0  initial release
// ============================================================================
module goal_detector #(
    parameter int SAMPLE_DIV  = 1000000,
    parameter int DEB_LEN     = 8,
    parameter int HOLDOFF_CYC = 50000000,
    parameter int STUCK_CYC   = 300000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_n,
    input  logic       enable,
    input  logic       clr,
    output logic       goal_pulse,
    output logic [7:0] goal_cnt,
    output logic       busy,
    output logic       fault
);

    localparam int                 CW           = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0]      C_TICK_LAST  = CW'(SAMPLE_DIV - 1);
    localparam logic [31:0]        C_HOLDOFF    = 32'(HOLDOFF_CYC);
    localparam logic [31:0]        C_STUCK_LAST = 32'(STUCK_CYC - 1);
    localparam logic [DEB_LEN-1:0] C_ALL_ONES   = {DEB_LEN{1'b1}};
    localparam logic [DEB_LEN-1:0] C_ALL_ZEROS  = {DEB_LEN{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLOCKED = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // Synchronizer and sampling chain
    logic               sync1_q;
    logic               sync2_q;
    logic [CW-1:0]      tick_cnt_q;
    logic [CW-1:0]      tick_cnt_d;
    logic               tick;
    logic [DEB_LEN-1:0] shift_q;
    logic [DEB_LEN-1:0] shift_d;
    logic               deb_q;
    logic               deb_d;
    logic               rise_q;
    logic               fall_q;

    // Goal state machine
    state_t             state_q;
    state_t             state_d;
    logic [31:0]        timer_q;
    logic [31:0]        timer_d;
    logic               pulse_q;
    logic               pulse_d;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic               busy_q;
    logic               fault_q;

    // Two-flop synchronizer; the inversion makes 1 mean "beam blocked"
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~sensor_n;
            sync2_q <= sync1_q;
        end
    end

    // Sample tick generation and hysteresis level decision
    always_comb begin
        tick       = (tick_cnt_q == C_TICK_LAST);
        tick_cnt_d = tick ? '0 : (tick_cnt_q + CW'(1));
        shift_d    = shift_q;
        deb_d      = deb_q;
        if (tick) begin
            shift_d = {shift_q[DEB_LEN-2:0], sync2_q};
            if (shift_d == C_ALL_ONES) begin
                deb_d = 1'b1;
            end else if (shift_d == C_ALL_ZEROS) begin
                deb_d = 1'b0;
            end
        end
    end

    // Debounce registers; rise/fall flags mark the first cycle of a new level
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            shift_q    <= '0;
            deb_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            shift_q    <= shift_d;
            deb_q      <= deb_d;
            rise_q     <= deb_d & ~deb_q;
            fall_q     <= ~deb_d & deb_q;
        end
    end

    // Next-state, shared timer, goal pulse and tally decisions
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // enable only matters on the edge that starts a new ball
                if (rise_q) begin
                    state_d = ST_BLOCKED;
                    timer_d = '0;
                    pulse_d = enable;
                end
            end
            ST_BLOCKED: begin
                timer_d = timer_q + 32'd1;
                if (fall_q) begin
                    state_d = ST_HOLDOFF;
                    timer_d = C_HOLDOFF;
                end else if (timer_q == C_STUCK_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_HOLDOFF: begin
                if (timer_q != 32'd0) begin
                    timer_d = timer_q - 32'd1;
                end
                // A re-block inside the window is the same ball rattling
                if (rise_q) begin
                    state_d = ST_BLOCKED;
                    timer_d = '0;
                end else if ((timer_q == 32'd0) && !deb_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (!deb_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // clr takes priority over a coincident goal
        if (clr) begin
            cnt_d = '0;
        end else if (pulse_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State, timer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign goal_pulse = pulse_q;
    assign goal_cnt   = cnt_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule
`default_nettype wire
